// File: rtl/spi_pkg.sv
// Shared definitions for the NITTA <-> SPI splitters: subframe sizing
// helpers and the two-state transfer FSM encoding.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } spi_state_t;

  // Number of SPI subframes that make up one NITTA word.
  function automatic int unsigned subframe_number(input int unsigned data_width,
                                                  input int unsigned spi_data_width);
    return data_width / spi_data_width;
  endfunction

  // Counter must hold the value SUBFRAME_NUMBER itself, hence the +1.
  function automatic int unsigned counter_width(input int unsigned data_width,
                                                input int unsigned spi_data_width);
    return $clog2(data_width / spi_data_width) + 1;
  endfunction

endpackage

// File: rtl/spi_ready_edge_detector.sv
// Detects the 0->1 transition of the SPI engine ready level, which marks
// that the currently offered byte has been taken.
module spi_ready_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic spi_ready,
  output logic consume
);

  logic spi_ready_prev;

  // Previous sample resets high so a ready line that is already high out of
  // reset is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (rst) spi_ready_prev <= 1'b1;
    else     spi_ready_prev <= spi_ready;
  end

  assign consume = spi_ready & ~spi_ready_prev;

endmodule

// File: rtl/nitta_to_spi_splitter.sv
// Transmit serializer: takes one NITTA word and hands it to the SPI slave
// engine as MSB-first subframes. A one-word holding register lets the next
// word be posted while the current one is still shifting out.
module nitta_to_spi_splitter
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SPI_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      nitta_valid,
  input  logic [DATA_WIDTH-1:0]     from_nitta,
  output logic                      splitter_busy,
  input  logic                      spi_ready,
  output logic [SPI_DATA_WIDTH-1:0] to_spi,
  output logic                      to_spi_valid,
  output logic                      frame_done
);

  localparam int unsigned SUBFRAME_NUMBER = subframe_number(DATA_WIDTH, SPI_DATA_WIDTH);
  localparam int unsigned CNT_W           = counter_width(DATA_WIDTH, SPI_DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(SUBFRAME_NUMBER);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  spi_state_t            state, state_n;
  logic [DATA_WIDTH-1:0] hold, hold_n;
  logic                  hold_full, hold_full_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  frame_done_n;
  logic                  consume;

  spi_ready_edge_detector u_edge (
    .clk       (clk),
    .rst       (rst),
    .spi_ready (spi_ready),
    .consume   (consume)
  );

  // All outputs come straight from flops: the shift register is cleared on
  // return to IDLE, so its top slice already reads zero when nothing is sent.
  assign to_spi        = shift[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
  assign to_spi_valid  = (state == SEND);
  assign splitter_busy = hold_full;

  // State, holding register, shifter and counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shift      <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      shift      <= shift_n;
      cnt        <= cnt_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state logic: accept into the holding register, move held word into
  // the shifter, and step through subframes on each consume.
  // Accept requires hold empty and reload requires hold full, so the two
  // writes to hold_full_n never collide in the same cycle.
  always_comb begin
    state_n      = state;
    hold_n       = hold;
    hold_full_n  = hold_full;
    shift_n      = shift;
    cnt_n        = cnt;
    frame_done_n = 1'b0;

    if (nitta_valid && !hold_full) begin
      hold_n      = from_nitta;
      hold_full_n = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (hold_full) begin
          shift_n     = hold;
          cnt_n       = CNT_FULL;
          hold_full_n = 1'b0;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (consume) begin
          if (cnt > CNT_ONE) begin
            shift_n = shift << SPI_DATA_WIDTH;
            cnt_n   = cnt - CNT_ONE;
          end else begin
            frame_done_n = 1'b1;
            if (hold_full) begin
              shift_n     = hold;
              cnt_n       = CNT_FULL;
              hold_full_n = 1'b0;
            end else begin
              shift_n = '0;
              cnt_n   = '0;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nitta_to_spi_splitter.sv
// Directed bench for nitta_to_spi_splitter: a 32/8 instance for the main
// scenarios and a 16/16 instance for the single-subframe case.
module tb_nitta_to_spi_splitter;

  logic        clk = 1'b0;
  logic        rst;

  logic        nitta_valid;
  logic [31:0] from_nitta;
  logic        splitter_busy;
  logic        spi_ready;
  logic [7:0]  to_spi;
  logic        to_spi_valid;
  logic        frame_done;

  logic        nitta_valid16;
  logic [15:0] from_nitta16;
  logic        splitter_busy16;
  logic        spi_ready16;
  logic [15:0] to_spi16;
  logic        to_spi_valid16;
  logic        frame_done16;

  int checks = 0;
  int errors = 0;
  logic fd_seen;

  nitta_to_spi_splitter #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .nitta_valid   (nitta_valid),
    .from_nitta    (from_nitta),
    .splitter_busy (splitter_busy),
    .spi_ready     (spi_ready),
    .to_spi        (to_spi),
    .to_spi_valid  (to_spi_valid),
    .frame_done    (frame_done)
  );

  nitta_to_spi_splitter #(.DATA_WIDTH(16), .SPI_DATA_WIDTH(16)) dut16 (
    .clk           (clk),
    .rst           (rst),
    .nitta_valid   (nitta_valid16),
    .from_nitta    (from_nitta16),
    .splitter_busy (splitter_busy16),
    .spi_ready     (spi_ready16),
    .to_spi        (to_spi16),
    .to_spi_valid  (to_spi_valid16),
    .frame_done    (frame_done16)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SPI byte handshake on the 32/8 instance: ready low, then high.
  task automatic xfer();
    spi_ready = 1'b0;
    tick();
    spi_ready = 1'b1;
    tick();
  endtask

  task automatic post(input logic [31:0] w);
    nitta_valid = 1'b1;
    from_nitta  = w;
    tick();
    nitta_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    nitta_valid = 1'b0; from_nitta = '0; spi_ready = 1'b1;
    nitta_valid16 = 1'b0; from_nitta16 = '0; spi_ready16 = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_valid", {31'd0, to_spi_valid}, 32'd0);
    chk("rst_to_spi", {24'd0, to_spi}, 32'd0);
    chk("rst_busy", {31'd0, splitter_busy}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    tick();

    // Single word
    post(32'hDEADBEEF);
    chk("sw_busy_after_accept", {31'd0, splitter_busy}, 32'd1);
    chk("sw_valid_lat1", {31'd0, to_spi_valid}, 32'd0);
    tick();
    chk("sw_valid_lat2", {31'd0, to_spi_valid}, 32'd1);
    chk("sw_b0", {24'd0, to_spi}, 32'hDE);
    chk("sw_busy_free", {31'd0, splitter_busy}, 32'd0);
    xfer(); chk("sw_b1", {24'd0, to_spi}, 32'hAD);
    xfer(); chk("sw_b2", {24'd0, to_spi}, 32'hBE);
    xfer(); chk("sw_b3", {24'd0, to_spi}, 32'hEF);
    chk("sw_fd_early", {31'd0, frame_done}, 32'd0);
    xfer();
    chk("sw_fd", {31'd0, frame_done}, 32'd1);
    chk("sw_valid_end", {31'd0, to_spi_valid}, 32'd0);
    chk("sw_to_spi_end", {24'd0, to_spi}, 32'd0);
    tick();
    chk("sw_fd_one_cycle", {31'd0, frame_done}, 32'd0);

    // Back-to-back words
    post(32'h01020304);
    tick();
    chk("bb_b0", {24'd0, to_spi}, 32'h01);
    post(32'hA0B0C0D0);
    chk("bb_busy", {31'd0, splitter_busy}, 32'd1);
    xfer(); chk("bb_b1", {24'd0, to_spi}, 32'h02);
    xfer(); chk("bb_b2", {24'd0, to_spi}, 32'h03);
    xfer(); chk("bb_b3", {24'd0, to_spi}, 32'h04);
    chk("bb_busy_hold", {31'd0, splitter_busy}, 32'd1);
    spi_ready = 1'b0; tick();
    chk("bb_valid_mid", {31'd0, to_spi_valid}, 32'd1);
    spi_ready = 1'b1; tick();
    chk("bb_b4", {24'd0, to_spi}, 32'hA0);
    chk("bb_valid_nogap", {31'd0, to_spi_valid}, 32'd1);
    chk("bb_fd1", {31'd0, frame_done}, 32'd1);
    chk("bb_busy_fall", {31'd0, splitter_busy}, 32'd0);
    xfer(); chk("bb_b5", {24'd0, to_spi}, 32'hB0);
    chk("bb_fd1_one_cycle", {31'd0, frame_done}, 32'd0);
    xfer(); chk("bb_b6", {24'd0, to_spi}, 32'hC0);
    xfer(); chk("bb_b7", {24'd0, to_spi}, 32'hD0);
    xfer();
    chk("bb_fd2", {31'd0, frame_done}, 32'd1);
    chk("bb_valid_end", {31'd0, to_spi_valid}, 32'd0);

    // Overflow: third word posted while busy is dropped
    post(32'h11111111);
    tick();
    post(32'h22222222);
    post(32'h33333333);
    chk("ov_busy", {31'd0, splitter_busy}, 32'd1);
    chk("ov_b0", {24'd0, to_spi}, 32'h11);
    xfer(); xfer(); xfer();
    chk("ov_b3", {24'd0, to_spi}, 32'h11);
    xfer();
    chk("ov_b4", {24'd0, to_spi}, 32'h22);
    xfer(); xfer(); xfer();
    chk("ov_b7", {24'd0, to_spi}, 32'h22);
    xfer();
    chk("ov_fd", {31'd0, frame_done}, 32'd1);
    tick(); tick(); tick();
    chk("ov_dropped_valid", {31'd0, to_spi_valid}, 32'd0);
    chk("ov_dropped_busy", {31'd0, splitter_busy}, 32'd0);

    // Stall: ready held high, then held low
    post(32'hCAFEF00D);
    tick();
    fd_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_done) fd_seen = 1'b1;
    end
    chk("st_high_byte", {24'd0, to_spi}, 32'hCA);
    chk("st_high_fd", {31'd0, fd_seen}, 32'd0);
    spi_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_done) fd_seen = 1'b1;
    end
    chk("st_low_byte", {24'd0, to_spi}, 32'hCA);
    chk("st_low_fd", {31'd0, fd_seen}, 32'd0);
    chk("st_low_valid", {31'd0, to_spi_valid}, 32'd1);
    spi_ready = 1'b1; tick();
    chk("st_b1", {24'd0, to_spi}, 32'hFE);
    xfer(); chk("st_b2", {24'd0, to_spi}, 32'hF0);
    xfer(); chk("st_b3", {24'd0, to_spi}, 32'h0D);
    xfer(); chk("st_fd", {31'd0, frame_done}, 32'd1);

    // Reset mid-frame with a word waiting in the holding register
    post(32'h89ABCDEF);
    tick();
    xfer(); xfer();
    chk("rm_b2", {24'd0, to_spi}, 32'hCD);
    post(32'h12345678);
    chk("rm_busy_pre", {31'd0, splitter_busy}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rm_valid", {31'd0, to_spi_valid}, 32'd0);
    chk("rm_busy", {31'd0, splitter_busy}, 32'd0);
    chk("rm_to_spi", {24'd0, to_spi}, 32'd0);
    chk("rm_fd", {31'd0, frame_done}, 32'd0);
    tick(); tick();
    chk("rm_held_discarded", {31'd0, to_spi_valid}, 32'd0);
    post(32'h00000055);
    tick();
    chk("rm_n0", {24'd0, to_spi}, 32'h00);
    chk("rm_n0_valid", {31'd0, to_spi_valid}, 32'd1);
    xfer(); chk("rm_n1", {24'd0, to_spi}, 32'h00);
    xfer(); chk("rm_n2", {24'd0, to_spi}, 32'h00);
    xfer(); chk("rm_n3", {24'd0, to_spi}, 32'h55);
    xfer(); chk("rm_fd_end", {31'd0, frame_done}, 32'd1);

    // Single-subframe configuration
    nitta_valid16 = 1'b1; from_nitta16 = 16'hBEEF;
    tick();
    nitta_valid16 = 1'b0;
    tick();
    chk("p16_byte", {16'd0, to_spi16}, 32'hBEEF);
    chk("p16_valid", {31'd0, to_spi_valid16}, 32'd1);
    spi_ready16 = 1'b0; tick();
    chk("p16_fd_early", {31'd0, frame_done16}, 32'd0);
    spi_ready16 = 1'b1; tick();
    chk("p16_fd", {31'd0, frame_done16}, 32'd1);
    chk("p16_valid_end", {31'd0, to_spi_valid16}, 32'd0);
    chk("p16_to_spi_end", {16'd0, to_spi16}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
